// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined N-bit adder: default geometry and the
// slice-add function used by each pipeline stage.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SEG   = 4;
  localparam int SLICE_MAX     = 64;

  typedef struct packed {
    logic                 c_msb;
    logic                 cout;
    logic [SLICE_MAX-1:0] sum;
  } slice_res_t;

  // Adds the low seg bits of a and b plus cin. Also reports the carry into
  // bit seg-1, which the top stage needs for signed overflow.
  function automatic slice_res_t slice_add(
    input logic [SLICE_MAX-1:0] a,
    input logic [SLICE_MAX-1:0] b,
    input logic                 cin,
    input int                   seg
  );
    logic [SLICE_MAX-1:0] mask;
    logic [SLICE_MAX-1:0] am;
    logic [SLICE_MAX-1:0] bm;
    logic [SLICE_MAX:0]   full;
    logic [SLICE_MAX:0]   pick;
    slice_res_t           r;
    mask    = ~({SLICE_MAX{1'b1}} << seg);
    am      = a & mask;
    bm      = b & mask;
    full    = {1'b0, am} + {1'b0, bm} + {{SLICE_MAX{1'b0}}, cin};
    pick    = {{SLICE_MAX{1'b0}}, 1'b1} << seg;
    r.sum   = full[SLICE_MAX-1:0] & mask;
    r.cout  = |(full & pick);
    r.c_msb = |((am ^ bm ^ full[SLICE_MAX-1:0]) & pick[SLICE_MAX:1]);
    return r;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SEG-bit slice adder; one instance per pipeline stage.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SEG = DEFAULT_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  slice_res_t res;

  assign res   = slice_add(SLICE_MAX'(a), SLICE_MAX'(b), cin, SEG);
  assign sum   = res.sum[SEG-1:0];
  assign cout  = res.cout;
  assign c_msb = res.c_msb;

  // The function works at a fixed maximum width; the bits above SEG are
  // always zero.
  if (SEG < SLICE_MAX) begin : g_pad
    logic unused_pad;
    assign unused_pad = |res.sum[SLICE_MAX-1:SEG];
  end

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG-bit slice per stage with a
// registered carry between stages and a valid/ready handshake on both sides.
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  input  logic             sub_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out
);

  localparam int STAGES = WIDTH / SEG;

  if (SEG < 1 || SEG > SLICE_MAX) begin : g_bad_seg
    $error("adder_pipe_nbit: SEG must be in 1..%0d", SLICE_MAX);
  end
  if (WIDTH % SEG != 0) begin : g_bad_width
    $error("adder_pipe_nbit: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
  end

  // Stage registers: index k holds the result of slice k.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              ovf_q;

  // Inputs presented to each stage's slice (from the ports for stage 0).
  logic [STAGES-1:0] v_st;
  logic [STAGES-1:0] c_st;
  logic [WIDTH-1:0]  a_st [STAGES];
  logic [WIDTH-1:0]  b_st [STAGES];
  logic [WIDTH-1:0]  s_st [STAGES];
  logic [WIDTH-1:0]  s_nx [STAGES];

  logic [SEG-1:0]    slice_sum  [STAGES];
  logic [STAGES-1:0] slice_cout;
  logic              slice_cmsb [STAGES];

  logic adv;

  // The whole pipe moves together; it only freezes when the output beat is
  // waiting on a downstream that is not ready.
  assign adv       = ready_in | ~valid_out;
  assign ready_out = adv;

  always_comb begin
    // Subtraction is A + ~B + 1: invert B once on entry and force carry-in.
    a_st[0] = a_in;
    b_st[0] = b_in ^ {WIDTH{sub_in}};
    s_st[0] = '0;
    c_st[0] = sub_in | carry_in;
    v_st[0] = valid_in;
    for (int k = 1; k < STAGES; k++) begin
      a_st[k] = a_q[k-1];
      b_st[k] = b_q[k-1];
      s_st[k] = s_q[k-1];
      c_st[k] = c_q[k-1];
      v_st[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.SEG(SEG)) u_slice (
      .a     (a_st[k][k*SEG +: SEG]),
      .b     (b_st[k][k*SEG +: SEG]),
      .cin   (c_st[k]),
      .sum   (slice_sum[k]),
      .cout  (slice_cout[k]),
      .c_msb (slice_cmsb[k])
    );

    // Only the top slice's MSB carry feeds overflow, and the last stage has
    // no successor to forward operands to.
    if (k == STAGES - 1) begin : g_last
      logic unused_tail;
      assign unused_tail = ^{a_q[k], b_q[k]};
    end else begin : g_inner
      logic unused_cmsb;
      assign unused_cmsb = slice_cmsb[k];
    end
  end

  // Merge each slice's partial sum into the running sum word.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_nx[k]                = s_st[k];
      s_nx[k][k*SEG +: SEG] = slice_sum[k];
    end
  end

  // NOTE: datapath registers are reset too, so sum/carry/overflow read as 0
  // while in reset and no stale result is visible after release.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      // NOTE: non-blocking assignments so every stage samples the values of
      // its predecessor from before this edge, regardless of statement order.
      v_q   <= v_st;
      c_q   <= slice_cout;
      ovf_q <= slice_cmsb[STAGES-1] ^ slice_cout[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_st[k];
        b_q[k] <= b_st[k];
        s_q[k] <= s_nx[k];
      end
    end
  end

  assign valid_out    = v_q[STAGES-1];
  assign sum_out      = s_q[STAGES-1];
  assign carry_out    = c_q[STAGES-1];
  assign overflow_out = ovf_q;

endmodule

// File: doc/adder_pipe_nbit.md
Name: adder_pipe_nbit

Overview:
- Parametrised, pipelined successor to the team's 1-bit full adder.
- Adds or subtracts two WIDTH-bit operands in SEG-bit slices, one slice per clock stage, with a registered carry between stages.
- A valid/ready handshake on both sides allows full throughput of one result per cycle, plus backpressure.
- Sits in the datapath wherever WIDTH is too large for a single-cycle ripple add at target clock.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be an integer multiple of SEG; violation is an elaboration error.
- SEG, 4, slice width added per pipeline stage.
- STAGES, WIDTH/SEG, derived (localparam); pipeline depth and latency in cycles.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- valid_in  input  1  operand beat present.
- ready_out  output  1  block accepts a beat this cycle.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- carry_in  input  1  carry-in. Used only when sub_in=0.
- sub_in  input  1  0 = A+B+carry_in; 1 = A-B (A + ~B + 1).
- valid_out  output  1  result beat present.
- ready_in  input  1  downstream accepts result.
- sum_out  output  WIDTH  result, modulo 2^WIDTH.
- carry_out  output  1  carry out of MSB. For subtract, 1 means no borrow (A>=B unsigned).
- overflow_out  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync deassert by the clock domain): every stage valid bit = 0; all data/carry registers = 0; valid_out=0, sum_out=0, carry_out=0, overflow_out=0. Any in-flight beats are discarded; nothing is emitted after release until new input arrives.
- Global advance: adv = ready_in OR NOT valid_out. ready_out = adv (combinational).
- Transfer rules:
  - Input transfer occurs when valid_in AND ready_out.
  - Output transfer occurs when valid_out AND ready_in.
- Stage k (0..STAGES-1), when adv:
  - Adds slice k of A and slice k of B' (B' = sub_in ? ~B : B), plus the carry from stage k-1.
  - For stage 0, the carry is (sub_in ? 1 : carry_in).
  - Stores the SEG-bit partial sum and the slice carry.
  - Forwards the not-yet-added upper slices of A/B' and the already-computed lower sum slices.
- When adv=0, all stage registers hold; no beat is lost or duplicated.
- A bubble (valid_in=0 on accept) propagates as a cleared valid bit. Data registers may hold stale values, but outputs qualified by valid_out must be correct.
- Latency: a beat accepted at cycle t appears with valid_out=1 at cycle t+STAGES, given no stalls. Each stall cycle adds one.
- Throughput: 1 beat/cycle while ready_in=1.
- overflow_out uses the carry into bit WIDTH-1. This is computed inside the last stage, so the slice adder must expose its internal MSB-1 carry.
- Outputs hold stable while valid_out=1 and ready_in=0.
- STAGES=1 (SEG=WIDTH) degenerates to a single registered adder with identical handshake.
- Simultaneous input accept and output drain in the same cycle is legal and required at full rate.

Decomposition:
- Shared package adder_pkg:
  - localparam defaults WIDTH/SEG.
  - A function computing the slice sum {carry, sum} and the MSB-1 carry, used by RTL and by the bench model.
- One sub-module: adder_slice (parameter SEG):
  - Combinational SEG-bit add with inputs a, b, cin.
  - Outputs sum, cout, c_msb (carry into top bit).
  - Instantiated STAGES times via generate.
- The pipeline registers and handshake stay in adder_pipe_nbit.

Test Plan (WIDTH=16, SEG=4, STAGES=4):
- Basic add: a=0x1234, b=0x0FFF, carry_in=1, sub=0, ready_in=1 -> 4 cycles later valid_out=1, sum=0x2234, carry_out=0, overflow=0.
- Carry ripple across all slices: a=0xFFFF, b=0x0000, carry_in=1 -> sum=0x0000, carry_out=1, overflow=0. Then a=0x7FFF, b=0x0001, carry_in=0 -> sum=0x8000, overflow=1, carry_out=0.
- Subtract: sub=1, a=0x0005, b=0x0007, carry_in=1 (ignored) -> sum=0xFFFE, carry_out=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, overflow=1, carry_out=1.
- Full-rate stream with backpressure:
  - Drive 20 random beats back-to-back.
  - Hold ready_in=0 for cycles 7-9.
  - Required: ready_out=0 during the stall with a full pipe; outputs stable during the stall; all 20 results match the model, in order, with none dropped or duplicated.
- Bubbles: valid_in pattern 1,0,1,0,0,1 -> valid_out pattern identical, shifted by 4 cycles.
- Reset mid-operation:
  - Assert rst_n_in=0 asynchronously while 3 beats are in flight.
  - Required: valid_out/sum/carry/overflow go to 0 immediately, without waiting for a clock edge.
  - After release with valid_in=0, valid_out stays 0 for 10 cycles.
